// File: rtl/bt_cmd_decode.sv
// bt_cmd_decode: UART 8N1 receiver feeding a two-byte (0xA5, cmd) frame parser that
// turns PREV/NEXT commands into single-cycle step pulses spaced at least GAP clocks apart.
module bt_cmd_decode #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 9600,
   parameter int GAP    = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [2:0] prev,
   output logic [2:0] next,
   output logic       cmd_err,
   output logic       drop,
   output logic       busy
);

   localparam int DIV   = CLK_HZ / BAUD;
   localparam int CNT_W = $clog2(DIV + 1);
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(DIV - 1);
   localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
   localparam logic [7:0]       HDR_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic {
      P_HDR = 1'b0,
      P_CMD = 1'b1
   } p_state_t;

   logic             sync1_r, sync2_r, line_prev_r;
   rx_state_t        rx_state_r, rx_state_s;
   logic [CNT_W-1:0] baud_cnt_r;
   logic [2:0]       bit_cnt_r;
   logic [7:0]       shift_r;
   logic             fall_s, tick_half_s, tick_full_s;
   logic             shift_en_s, byte_stb_s, frame_err_s;

   p_state_t         p_state_r, p_state_s;
   logic             cmd_valid_s, cmd_bad_s;
   logic             new_op_s;
   logic [2:0]       new_step_s;

   logic [GAP_W-1:0] gap_r, gap_s;
   logic             slot_v_r, slot_v_s, slot_op_r, slot_op_s;
   logic [2:0]       slot_step_r, slot_step_s;
   logic             gap_zero_s, issue_slot_s, issue_new_s, store_s, drop_s;
   logic [2:0]       prev_s, next_s;
   logic [2:0]       prev_r, next_r;
   logic             cmd_err_r, drop_r, busy_r;

   assign fall_s      = line_prev_r & ~sync2_r;
   assign tick_half_s = (baud_cnt_r == HALF_M1);
   assign tick_full_s = (baud_cnt_r == FULL_M1);
   assign new_op_s    = shift_r[7];
   assign new_step_s  = shift_r[2:0];

   // two-flop synchronizer plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r     <= 1'b1;
         sync2_r     <= 1'b1;
         line_prev_r <= 1'b1;
      end else begin
         sync1_r     <= rxd;
         sync2_r     <= sync1_r;
         line_prev_r <= sync2_r;
      end
   end

   // receiver state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_r <= RX_IDLE;
      end else begin
         rx_state_r <= rx_state_s;
      end
   end

   // receiver next-state logic
   always_comb begin
      rx_state_s = rx_state_r;
      case (rx_state_r)
         RX_IDLE: begin
            if (fall_s) rx_state_s = RX_START;
            else        rx_state_s = RX_IDLE;
         end
         RX_START: begin
            if (tick_half_s) rx_state_s = sync2_r ? RX_IDLE : RX_DATA;
            else             rx_state_s = RX_START;
         end
         RX_DATA: begin
            if (tick_full_s && (bit_cnt_r == 3'd7)) rx_state_s = RX_STOP;
            else                                    rx_state_s = RX_DATA;
         end
         RX_STOP: begin
            if (tick_full_s) rx_state_s = RX_IDLE;
            else             rx_state_s = RX_STOP;
         end
         default: rx_state_s = RX_IDLE;
      endcase
   end

   // receiver outputs: data-bit shift enable and end-of-frame strobes
   always_comb begin
      shift_en_s  = 1'b0;
      byte_stb_s  = 1'b0;
      frame_err_s = 1'b0;
      case (rx_state_r)
         RX_DATA: shift_en_s = tick_full_s;
         RX_STOP: begin
            if (tick_full_s) begin
               byte_stb_s  = sync2_r;
               frame_err_s = ~sync2_r;
            end else begin
               byte_stb_s  = 1'b0;
               frame_err_s = 1'b0;
            end
         end
         default: shift_en_s = 1'b0;
      endcase
   end

   // bit-period counter restarts on every state change and at each data-bit sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt_r <= CNT_ZERO;
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'h00;
      end else begin
         if ((rx_state_r == RX_IDLE) || (rx_state_s != rx_state_r) || tick_full_s) begin
            baud_cnt_r <= CNT_ZERO;
         end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
         end
         if (rx_state_r != RX_DATA) begin
            bit_cnt_r <= 3'd0;
         end else if (shift_en_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
         end
         if (shift_en_s) begin
            shift_r <= {sync2_r, shift_r[7:1]};
         end
      end
   end

   // frame parser state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_state_r <= P_HDR;
      end else begin
         p_state_r <= p_state_s;
      end
   end

   // frame parser next-state logic; a repeated header keeps waiting for the command
   always_comb begin
      p_state_s = p_state_r;
      if (byte_stb_s) begin
         case (p_state_r)
            P_HDR:   p_state_s = (shift_r == HDR_BYTE) ? P_CMD : P_HDR;
            P_CMD:   p_state_s = (shift_r == HDR_BYTE) ? P_CMD : P_HDR;
            default: p_state_s = P_HDR;
         endcase
      end else begin
         p_state_s = p_state_r;
      end
   end

   // frame parser outputs: classify the command byte
   always_comb begin
      cmd_valid_s = 1'b0;
      cmd_bad_s   = 1'b0;
      if (byte_stb_s && (p_state_r == P_CMD) && (shift_r != HDR_BYTE)) begin
         if (((shift_r[7:6] == 2'b01) || (shift_r[7:6] == 2'b10)) && (new_step_s != 3'd0)) begin
            cmd_valid_s = 1'b1;
         end else begin
            cmd_bad_s = 1'b1;
         end
      end else begin
         cmd_valid_s = 1'b0;
         cmd_bad_s   = 1'b0;
      end
   end

   // issue arbitration: the pending slot always wins over a fresh command
   always_comb begin
      gap_zero_s   = (gap_r == GAP_ZERO);
      issue_slot_s = gap_zero_s & slot_v_r;
      issue_new_s  = cmd_valid_s & gap_zero_s & ~slot_v_r;
      store_s      = cmd_valid_s & ((~gap_zero_s & ~slot_v_r) | issue_slot_s);
      drop_s       = cmd_valid_s & ~gap_zero_s & slot_v_r;
      prev_s       = 3'd0;
      next_s       = 3'd0;
      gap_s        = gap_r;
      slot_v_s     = slot_v_r;
      slot_op_s    = slot_op_r;
      slot_step_s  = slot_step_r;
      if (issue_slot_s) begin
         if (slot_op_r) next_s = slot_step_r;
         else           prev_s = slot_step_r;
      end else if (issue_new_s) begin
         if (new_op_s) next_s = new_step_s;
         else          prev_s = new_step_s;
      end else begin
         prev_s = 3'd0;
         next_s = 3'd0;
      end
      if (issue_slot_s || issue_new_s) begin
         gap_s = GAP_LOAD;
      end else if (!gap_zero_s) begin
         gap_s = gap_r - GAP_ONE;
      end else begin
         gap_s = gap_r;
      end
      if (store_s) begin
         slot_v_s    = 1'b1;
         slot_op_s   = new_op_s;
         slot_step_s = new_step_s;
      end else if (issue_slot_s) begin
         slot_v_s = 1'b0;
      end else begin
         slot_v_s = slot_v_r;
      end
   end

   // gap counter, pending slot and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_r       <= GAP_ZERO;
         slot_v_r    <= 1'b0;
         slot_op_r   <= 1'b0;
         slot_step_r <= 3'd0;
         prev_r      <= 3'd0;
         next_r      <= 3'd0;
         cmd_err_r   <= 1'b0;
         drop_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         gap_r       <= gap_s;
         slot_v_r    <= slot_v_s;
         slot_op_r   <= slot_op_s;
         slot_step_r <= slot_step_s;
         prev_r      <= prev_s;
         next_r      <= next_s;
         cmd_err_r   <= frame_err_s | cmd_bad_s;
         drop_r      <= drop_s;
         busy_r      <= (gap_s != GAP_ZERO) | slot_v_s;
      end
   end

   assign prev    = prev_r;
   assign next    = next_r;
   assign cmd_err = cmd_err_r;
   assign drop    = drop_r;
   assign busy    = busy_r;

endmodule

// File: doc/bt_cmd_decode.md
BT_CMD_DECODE -- requirements
Module: bt_cmd_decode

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, UART bit rate; DIV = CLK_HZ/BAUD (integer divide, 10416 at defaults).
REQ-003 Parameter GAP, default 500000, minimum clock cycles between consecutive PREV/NEXT pulses.
REQ-004 CLK  input  1  system clock; all logic on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 RXD  input  1  UART 8N1 serial line from Bluetooth module, idle high, asynchronous to CLK.
REQ-007 PREV  output  3  step-back amount; nonzero for exactly one cycle per issued PREV command, else 0.
REQ-008 NEXT  output  3  step-forward amount; nonzero for exactly one cycle per issued NEXT command, else 0.
REQ-009 CMD_ERR  output  1  one-cycle pulse: bad command byte or UART stop-bit error.
REQ-010 DROP  output  1  one-cycle pulse: valid command discarded because pending slot full.
REQ-011 BUSY  output  1  high while gap counter nonzero or pending slot occupied.

Function
REQ-012 RXD shall pass through a 2-flop synchronizer; all RX logic uses the synchronized value.
REQ-013 RX FSM states IDLE, START, DATA, STOP; IDLE->START on synchronized high-to-low transition.
REQ-014 START: after DIV/2 cycles, line low -> DATA, line high -> IDLE (glitch, no error).
REQ-015 DATA: sample every DIV cycles, 8 bits, LSB first, then -> STOP.
REQ-016 STOP: sample after DIV cycles; high -> one-cycle internal byte strobe with data; low -> CMD_ERR pulse, byte discarded; both -> IDLE.
REQ-017 Frame = header 0xA5 then command byte; parser states HDR, CMD.
REQ-018 HDR: 0xA5 -> CMD; any other byte ignored silently.
REQ-019 CMD: 0xA5 -> stay CMD (resync); otherwise decode cmd[7:6]: 01 = PREV, 10 = NEXT, step = cmd[2:0]; cmd[5:3] ignored; -> HDR.
REQ-020 CMD: op 00/11 or step 0 -> CMD_ERR pulse, nothing issued, -> HDR.
REQ-021 Valid command, gap counter 0, slot empty -> PREV or NEXT = step in the cycle after the byte strobe; counter loaded GAP-1.
REQ-022 Gap counter decrements by 1 per cycle while nonzero; never wraps below 0.
REQ-023 Valid command while counter nonzero and slot empty -> stored in slot (op, step).
REQ-024 Counter 0 with slot occupied -> slot issued as one-cycle pulse, slot cleared, counter loaded GAP-1.
REQ-025 New valid command in same cycle as slot issue -> stored into the freed slot, not dropped.
REQ-026 New valid command while slot occupied and counter nonzero -> DROP pulse, command discarded, slot unchanged.
REQ-027 PREV and NEXT shall never be nonzero in the same cycle.
REQ-028 Consecutive issued pulses separated by at least GAP cycles (rising edge to rising edge).

Reset
REQ-029 RST_N low shall immediately force PREV=0, NEXT=0, CMD_ERR=0, DROP=0, BUSY=0, RX FSM IDLE, parser HDR, counter 0, slot empty, synchronizer flops 1.
REQ-030 Reset mid-frame or mid-gap discards all partial bytes, pending command and gap; after release the block behaves as from power-up.

Verification (bench: CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10, GAP=50)
REQ-031 Send 0xA5,0x83 -> NEXT=3 for one cycle, 1 cycle after second byte strobe; BUSY high 49 further cycles.
REQ-032 Send 0xA5,0x42 then 0xA5,0x81 back-to-back within gap -> PREV=2, then NEXT=1 exactly 50 cycles later; no DROP.
REQ-033 Send three frames 0xA5,0x41 within one gap -> two PREV=1 pulses 50 cycles apart, one DROP pulse on third.
REQ-034 Send 0xA5,0xC1 and 0xA5,0x80 -> CMD_ERR pulse each, PREV/NEXT stay 0; send 0x12,0xA5,0xA5,0x84 -> single NEXT=4.
REQ-035 Byte with stop bit low -> CMD_ERR pulse, parser unchanged; 3-cycle low glitch on RXD -> no byte, no error.
REQ-036 Assert RST_N low during data bit 4 of command byte and during gap with slot full -> all outputs 0 immediately, no later pulse; next full frame decodes normally.
